// File: rtl/datapath_pkg.sv
// Shared datapath constants: register-file geometry, shifter codes and
// the operand-fetch FSM state type.
package datapath_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREG   = 8;
   localparam int unsigned AW     = 3;

   // Encoding shared with the barrel shifter
   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD_A = 2'd1,
      RD_B = 2'd2,
      HOLD = 2'd3
   } of_state_t;

endpackage

// File: rtl/regfile_1r1w.sv
// N x DW register array: one asynchronous read port, one synchronous write
// port, synchronous clear on reset.
module regfile_1r1w #(
   parameter int unsigned DW = 16,
   parameter int unsigned N  = 8,
   parameter int unsigned A  = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [A-1:0]  waddr,
   input  logic [DW-1:0] wdata,
   input  logic [A-1:0]  raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < N; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/operand_fetch.sv
// Serial two-operand fetch (A from Rn, then B from Rm) feeding the shifter.
// Define OPERAND_FETCH_FWD_EN for write-to-read forwarding during RD_A/RD_B.
module operand_fetch
   import datapath_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AW-1:0]     req_rn,
   input  logic [AW-1:0]     req_rm,
   input  logic [1:0]        req_shift,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_num,
   input  logic [DATA_W-1:0] wr_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [1:0]        shift_out
);

   of_state_t         state, state_nx;
   logic [AW-1:0]     rn_q, rm_q, raddr;
   logic [DATA_W-1:0] rdata, operand;

   regfile_1r1w #(
      .DW (DATA_W),
      .N  (NREG),
      .A  (AW)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (wr_num),
      .wdata (wr_data),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      out_valid = 1'b0;
      raddr     = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = RD_A;
         end
         RD_A: begin
            raddr    = rn_q;
            state_nx = RD_B;
         end
         RD_B: begin
            raddr    = rm_q;
            state_nx = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
`ifdef OPERAND_FETCH_FWD_EN
      operand = (wr_en && (wr_num == raddr)) ? wr_data : rdata;
`else
      operand = rdata;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rn_q      <= '0;
         rm_q      <= '0;
         a_out     <= '0;
         b_out     <= '0;
         shift_out <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rn_q      <= req_rn;
                  rm_q      <= req_rm;
                  shift_out <= req_shift;
               end
            end
            RD_A:    a_out <= operand;
            RD_B:    b_out <= operand;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch; expectations follow
// OPERAND_FETCH_FWD_EN when the forwarding build is selected.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_rn, req_rm;
   logic [1:0]  req_shift;
   logic        wr_en;
   logic [2:0]  wr_num;
   logic [15:0] wr_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] a_out, b_out;
   logic [1:0]  shift_out;

   int total = 0;
   int bad   = 0;

   operand_fetch dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rn    (req_rn),
      .req_rm    (req_rm),
      .req_shift (req_shift),
      .wr_en     (wr_en),
      .wr_num    (wr_num),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_out     (a_out),
      .b_out     (b_out),
      .shift_out (shift_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  rn;
      logic [2:0]  rm;
      logic [1:0]  sh;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge; outputs are read there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] n, input logic [15:0] d);
      wr_en = 1'b1; wr_num = n; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic start(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh);
      int w = 0;
      while (!req_ready && w < 10) begin
         tick();
         w++;
      end
      if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_rn = rn; req_rm = rm; req_shift = sh;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("handoff_req_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic fetch_check(input string name, input logic [2:0] rn, input logic [2:0] rm,
                              input logic [1:0] sh, input logic [15:0] ea, input logic [15:0] eb);
      int lat;
      start(rn, rm, sh);
      wait_valid(lat);
      chk({name, "_latency"}, 32'(lat), 32'd3);
      chk({name, "_a"}, 32'(a_out), 32'(ea));
      chk({name, "_b"}, 32'(b_out), 32'(eb));
      chk({name, "_shift"}, 32'(shift_out), 32'(sh));
      handoff();
   endtask

   initial begin
      int lat;
      logic [15:0] exp_a, exp_b;

      vecs[0] = '{rn: 3'd2, rm: 3'd5, sh: 2'b01, ea: 16'h1234, eb: 16'h00F0};
      vecs[1] = '{rn: 3'd3, rm: 3'd3, sh: 2'b11, ea: 16'h8001, eb: 16'h8001};
      vecs[2] = '{rn: 3'd0, rm: 3'd7, sh: 2'b10, ea: 16'hA5A5, eb: 16'hFFFF};
      vecs[3] = '{rn: 3'd6, rm: 3'd1, sh: 2'b00, ea: 16'h7FFF, eb: 16'h0101};
      vecs[4] = '{rn: 3'd7, rm: 3'd0, sh: 2'b11, ea: 16'hFFFF, eb: 16'hA5A5};

      reset = 1'b1; req_valid = 1'b0; req_rn = '0; req_rm = '0; req_shift = '0;
      wr_en = 1'b0; wr_num = '0; wr_data = '0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();

      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_a", 32'(a_out), 32'd0);
      chk("rst_b", 32'(b_out), 32'd0);
      chk("rst_shift", 32'(shift_out), 32'd0);

      wr(3'd0, 16'hA5A5); wr(3'd1, 16'h0101); wr(3'd2, 16'h1234); wr(3'd3, 16'h8001);
      wr(3'd4, 16'h0011); wr(3'd5, 16'h00F0); wr(3'd6, 16'h7FFF); wr(3'd7, 16'hFFFF);

      for (int i = 0; i < 5; i++) begin
         fetch_check($sformatf("vec%0d", i), vecs[i].rn, vecs[i].rm, vecs[i].sh,
                     vecs[i].ea, vecs[i].eb);
      end

      // Downstream stall; a request held during HOLD must not be taken
      start(3'd2, 3'd5, 2'b01);
      wait_valid(lat);
      chk("stall_latency", 32'(lat), 32'd3);
      req_valid = 1'b1; req_rn = 3'd6; req_rm = 3'd7; req_shift = 2'b10;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_a", 32'(a_out), 32'h1234);
         chk("stall_b", 32'(b_out), 32'h00F0);
         chk("stall_shift", 32'(shift_out), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("stall_release_ready", 32'(req_ready), 32'd1);
      chk("stall_release_valid", 32'(out_valid), 32'd0);
      tick();
      req_valid = 1'b0;
      wait_valid(lat);
      chk("held_req_latency", 32'(lat), 32'd3);
      chk("held_req_a", 32'(a_out), 32'h7FFF);
      chk("held_req_b", 32'(b_out), 32'hFFFF);
      chk("held_req_shift", 32'(shift_out), 32'd2);
      handoff();

      // Write to R4 while B is being read; A was already captured
      start(3'd4, 3'd4, 2'b00);
      tick();
      wr(3'd4, 16'hBEEF);
      wait_valid(lat);
`ifdef OPERAND_FETCH_FWD_EN
      exp_b = 16'hBEEF;
`else
      exp_b = 16'h0011;
`endif
      chk("fwdb_stale_a", 32'(a_out), 32'h0011);
      chk("fwdb_b", 32'(b_out), 32'(exp_b));
      handoff();
      fetch_check("r4_after", 3'd4, 3'd4, 2'b01, 16'hBEEF, 16'hBEEF);

      // Write to R1 while A is being read
      start(3'd1, 3'd1, 2'b10);
      wr(3'd1, 16'h7777);
      wait_valid(lat);
`ifdef OPERAND_FETCH_FWD_EN
      exp_a = 16'h7777;
`else
      exp_a = 16'h0101;
`endif
      chk("fwda_a", 32'(a_out), 32'(exp_a));
      chk("fwda_b", 32'(b_out), 32'h7777);
      handoff();

      // Reset while in RD_B, with a request and a write also present
      start(3'd2, 3'd3, 2'b11);
      tick();
      reset = 1'b1; req_valid = 1'b1; req_rn = 3'd2;
      wr_en = 1'b1; wr_num = 3'd7; wr_data = 16'hFFFF;
      tick();
      reset = 1'b0; req_valid = 1'b0; wr_en = 1'b0;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_a", 32'(a_out), 32'd0);
      chk("midrst_b", 32'(b_out), 32'd0);
      chk("midrst_shift", 32'(shift_out), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("midrst_no_output", 32'(out_valid), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         fetch_check($sformatf("clr%0d", i), 3'(2 * i), 3'(2 * i + 1), 2'b01, 16'h0, 16'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
